// File: rtl/wssa_mac_top.sv
// Weight-stationary int8 matrix-multiply engine: C = A * B into a 16-bit-lane output BRAM.
// Define WSSA_SAT_EN to saturate each lane sum to int16 instead of wrapping.

module wssa_lane #(
  parameter int DW  = 8,
  parameter int ARR = 8,
  parameter int OW  = 16
) (
  input  logic [ARR-1:0][DW-1:0] a,
  input  logic [ARR-1:0][DW-1:0] w,
  input  logic                   en,
  output logic [OW-1:0]          sum
);
`ifdef WSSA_SAT_EN
  localparam int SW = 2*DW + 4;
`else
  localparam int SW = OW;
`endif

  logic signed [SW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int t = 0; t < ARR; t++)
      acc = acc + SW'($signed(a[t]) * $signed(w[t]));
  end

`ifdef WSSA_SAT_EN
  localparam logic signed [SW-1:0] MAXV = SW'(2**(OW-1) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(2**(OW-1)));

  always_comb begin
    if (!en)              sum = '0;
    else if (acc > MAXV)  sum = {1'b0, {(OW-1){1'b1}}};
    else if (acc < MINV)  sum = {1'b1, {(OW-1){1'b0}}};
    else                  sum = acc[OW-1:0];
  end
`else
  assign sum = en ? acc : '0;
`endif
endmodule

module wssa_mac_top #(
  parameter int DW  = 8,
  parameter int ARR = 8,
  parameter int OW  = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [11:0]         MNT,
  input  logic                START,
  output logic                DONE,
  output logic                EN_I,
  output logic [2:0]          ADDR_I,
  input  logic [ARR*DW-1:0]   RDATA_I,
  output logic                EN_W,
  output logic [2:0]          ADDR_W,
  input  logic [ARR*DW-1:0]   RDATA_W,
  output logic                EN_O,
  output logic                RW_O,
  output logic [3:0]          ADDR_O,
  output logic [ARR*OW-1:0]   WDATA_O,
  input  logic [ARR*OW-1:0]   RDATA_O
);
  localparam int STAGES = 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, WRITE, FINISH} state_t;
  typedef struct packed {
    logic [3:0] m;
    logic [3:0] n;
    logic [3:0] t;
  } dims_t;

  state_t                          state;
  dims_t                           dims, req;
  logic [ARR-1:0][ARR-1:0][DW-1:0] w_arr;
  logic [ARR-1:0][DW-1:0]          a_row, w_row;
  logic [ARR-1:0][OW-1:0]          lane_sum;
  logic                            w_vld;
  logic [2:0]                      w_col;
  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:0][2:0]            row_pipe;
  logic                            unused_rdata;

  function automatic logic [3:0] clamp(input logic [3:0] v);
    return (v > 4'd8) ? 4'd8 : v;
  endfunction

  assign req          = {clamp(MNT[11:8]), clamp(MNT[7:4]), clamp(MNT[3:0])};
  assign a_row        = RDATA_I;
  assign w_row        = RDATA_W;
  assign EN_I         = vld_pipe[0];
  assign ADDR_I       = row_pipe[0];
  assign unused_rdata = ^RDATA_O;

  // w_arr[j] is weight column j; lanes past N are gated off
  for (genvar j = 0; j < ARR; j++) begin : g_lane
    wssa_lane #(.DW(DW), .ARR(ARR), .OW(OW)) u_lane (
      .a   (a_row),
      .w   (w_arr[j]),
      .en  (4'(j) < dims.n),
      .sum (lane_sum[j])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      dims     <= '0;
      w_arr    <= '0;
      w_vld    <= 1'b0;
      w_col    <= '0;
      vld_pipe <= '0;
      row_pipe <= '0;
      DONE     <= 1'b0;
      EN_W     <= 1'b0;
      ADDR_W   <= '0;
      EN_O     <= 1'b0;
      RW_O     <= 1'b0;
      ADDR_O   <= '0;
      WDATA_O  <= '0;
    end else begin
      // weight row returns one cycle after its read; bytes t>=T are zeroed
      w_vld <= EN_W;
      w_col <= ADDR_W;
      if (w_vld)
        for (int t = 0; t < ARR; t++)
          w_arr[w_col][t] <= (4'(t) < dims.t) ? w_row[t] : '0;

      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
      for (int s = 1; s <= STAGES; s++) row_pipe[s] <= row_pipe[s-1];

      EN_O <= vld_pipe[STAGES];
      RW_O <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        ADDR_O  <= {1'b0, row_pipe[STAGES]};
        WDATA_O <= lane_sum;
      end

      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          dims  <= req;
          w_arr <= '0;
          if (req.m == 4'd0 || req.n == 4'd0 || req.t == 4'd0) begin
            state <= FINISH;
            DONE  <= 1'b1;
          end else begin
            state  <= LOAD_W;
            EN_W   <= 1'b1;
            ADDR_W <= '0;
          end
        end
        LOAD_W: begin
          if (ADDR_W == 3'(dims.n - 4'd1)) begin
            EN_W        <= 1'b0;
            state       <= COMPUTE;
            vld_pipe[0] <= 1'b1;
            row_pipe[0] <= '0;
          end else begin
            ADDR_W <= ADDR_W + 3'd1;
          end
        end
        COMPUTE: begin
          if (row_pipe[0] == 3'(dims.m - 4'd1)) begin
            state <= WRITE;
          end else begin
            vld_pipe[0] <= 1'b1;
            row_pipe[0] <= row_pipe[0] + 3'd1;
          end
        end
        // the last row is being written on this edge, so DONE lands one cycle later
        WRITE: if (EN_O && ADDR_O == {1'b0, 3'(dims.m - 4'd1)}) begin
          state <= FINISH;
          DONE  <= 1'b1;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wssa_mac_top.sv
// Randomized bench for wssa_mac_top: behavioural BRAMs plus an integer A*B reference model.
module tb_wssa_mac_top;
  logic         CLK = 1'b0;
  logic         RST, START, DONE, EN_I, EN_W, EN_O, RW_O;
  logic [11:0]  MNT;
  logic [2:0]   ADDR_I, ADDR_W;
  logic [3:0]   ADDR_O;
  logic [63:0]  RDATA_I, RDATA_W;
  logic [127:0] WDATA_O, RDATA_O;

  localparam logic [127:0] SENT = {8{16'hA5C3}};
  localparam logic [11:0]  B2B [8] = '{12'h444, 12'h337, 12'h374, 12'h376,
                                       12'h634, 12'h738, 12'h583, 12'h555};
`ifdef WSSA_SAT_EN
  localparam logic [15:0]  WRAP_EXP = 16'h8000;
`else
  localparam logic [15:0]  WRAP_EXP = 16'h4180;
`endif

  logic [63:0]  mem_i [8];
  logic [63:0]  mem_w [8];
  logic [127:0] mem_o [16];
  logic [142:0] outs;
  bit           clr_o;
  int           cur_m;
  int           pass_cnt = 0, chk_cnt = 0;
  int           done_cnt = 0, en_i_cnt = 0, en_w_cnt = 0, en_o_cnt = 0, oob_cnt = 0;

  assign RDATA_O = '0;
  assign outs = {DONE, EN_I, ADDR_I, EN_W, ADDR_W, EN_O, RW_O, ADDR_O, WDATA_O};

  wssa_mac_top dut (
    .CLK(CLK), .RST(RST), .MNT(MNT), .START(START), .DONE(DONE),
    .EN_I(EN_I), .ADDR_I(ADDR_I), .RDATA_I(RDATA_I),
    .EN_W(EN_W), .ADDR_W(ADDR_W), .RDATA_W(RDATA_W),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O), .RDATA_O(RDATA_O)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (EN_I) RDATA_I <= mem_i[ADDR_I];
    if (EN_W) RDATA_W <= mem_w[ADDR_W];
    if (clr_o) for (int r = 0; r < 16; r++) mem_o[r] <= SENT;
    else if (EN_O && RW_O) mem_o[ADDR_O] <= WDATA_O;
  end

  always @(posedge CLK) begin
    #1;
    if (DONE === 1'b1) done_cnt++;
    if (EN_I === 1'b1) en_i_cnt++;
    if (EN_W === 1'b1) en_w_cnt++;
    if (EN_O === 1'b1) en_o_cnt++;
    if (EN_O === 1'b1 && RW_O === 1'b1 && int'(ADDR_O) >= cur_m) oob_cnt++;
  end

  function automatic int clampf(input int v);
    return (v > 8) ? 8 : v;
  endfunction

  // C[i][j] = sum_{k<t} A[i][k]*B[k][j] with plain integers; untouched rows keep the sentinel
  function automatic logic [127:0] ref_row(input int i, input int m, input int n, input int t);
    logic [127:0] r;
    byte a, b;
    int s;
    if (i >= m) return SENT;
    r = '0;
    for (int j = 0; j < n; j++) begin
      s = 0;
      for (int k = 0; k < t; k++) begin
        a = mem_i[i][8*k +: 8];
        b = mem_w[j][8*k +: 8];
        s += int'(a) * int'(b);
      end
`ifdef WSSA_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`endif
      r[16*j +: 16] = 16'(s);
    end
    return r;
  endfunction

  task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
    for (int r = 0; r < 8; r++) begin
      mem_i[r] = {8{a}};
      mem_w[r] = {8{b}};
    end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 8; r++) begin
      mem_i[r] = {$urandom, $urandom};
      mem_w[r] = {$urandom, $urandom};
    end
  endtask

  // START pulse, then wait (bounded) for DONE; returns at the negedge of the DONE cycle
  task automatic run_job(input logic [11:0] mnt, output int cyc);
    @(negedge CLK);
    START = 1'b1;
    MNT   = mnt;
    clr_o = 1'b0;
    cur_m = clampf(int'(mnt[11:8]));
    @(negedge CLK);
    START = 1'b0;
    cyc   = 1;
    while (DONE !== 1'b1 && cyc < 64) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    chk_cnt++;
    if (outs !== '0) $display("FAIL reset_hold got %h want 0", outs); else pass_cnt++;
    RST = 1'b0;
    @(negedge CLK);
    chk_cnt++;
    if (outs !== '0) $display("FAIL reset_idle got %h want 0", outs); else pass_cnt++;
  endtask

  task automatic test_ones();
    logic [11:0]  mnt;
    logic [127:0] row0;
    int cyc, d0, o0, m, n, t;
    fill_const(8'h01, 8'h01);
    for (int k = 0; k < 2; k++) begin
      mnt  = (k == 0) ? 12'h888 : 12'h444;
      row0 = (k == 0) ? {8{16'h0008}} : {64'h0, {4{16'h0004}}};
      m = clampf(int'(mnt[11:8])); n = clampf(int'(mnt[7:4])); t = clampf(int'(mnt[3:0]));
      clr_o = 1'b1; d0 = done_cnt; o0 = oob_cnt;
      run_job(mnt, cyc);
      chk_cnt++;
      if (DONE !== 1'b1 || cyc > n + m + 8)
        $display("FAIL ones_latency mnt=%h got cyc=%0d done=%b want done within %0d", mnt, cyc, DONE, n + m + 8);
      else pass_cnt++;
      @(negedge CLK); @(negedge CLK);
      chk_cnt++;
      if (done_cnt - d0 != 1) $display("FAIL ones_done_pulses got %0d want 1", done_cnt - d0); else pass_cnt++;
      chk_cnt++;
      if (oob_cnt - o0 != 0) $display("FAIL ones_oob_writes got %0d want 0", oob_cnt - o0); else pass_cnt++;
      chk_cnt++;
      if (mem_o[0] !== row0) $display("FAIL ones_row0 mnt=%h got %h want %h", mnt, mem_o[0], row0); else pass_cnt++;
      for (int r = 0; r < 16; r++) begin
        chk_cnt++;
        if (mem_o[r] !== ref_row(r, m, n, t))
          $display("FAIL ones_row mnt=%h row%0d got %h want %h", mnt, r, mem_o[r], ref_row(r, m, n, t));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_wrap();
    int cyc;
    fill_const(8'h80, 8'h7F);
    clr_o = 1'b1;
    run_job(12'h113, cyc);
    chk_cnt++;
    if (DONE !== 1'b1) $display("FAIL wrap_done got cyc=%0d done=%b want done", cyc, DONE); else pass_cnt++;
    @(negedge CLK);
    chk_cnt++;
    if (mem_o[0] !== {112'h0, WRAP_EXP}) $display("FAIL wrap_row0 got %h want %h", mem_o[0], {112'h0, WRAP_EXP});
    else pass_cnt++;
    for (int r = 0; r < 16; r++) begin
      chk_cnt++;
      if (mem_o[r] !== ref_row(r, 1, 1, 3))
        $display("FAIL wrap_row row%0d got %h want %h", r, mem_o[r], ref_row(r, 1, 1, 3));
      else pass_cnt++;
    end
  endtask

  task automatic test_clamp();
    int cyc;
    fill_rand();
    clr_o = 1'b1;
    run_job(12'hFA9, cyc);
    chk_cnt++;
    if (DONE !== 1'b1 || cyc > 24) $display("FAIL clamp_latency got cyc=%0d done=%b want done within 24", cyc, DONE);
    else pass_cnt++;
    @(negedge CLK);
    for (int r = 0; r < 16; r++) begin
      chk_cnt++;
      if (mem_o[r] !== ref_row(r, 8, 8, 8))
        $display("FAIL clamp_row row%0d got %h want %h", r, mem_o[r], ref_row(r, 8, 8, 8));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc, d0, o0, m, n, t;
    fill_rand();
    clr_o = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m = int'(B2B[k][11:8]); n = int'(B2B[k][7:4]); t = int'(B2B[k][3:0]);
      d0 = done_cnt; o0 = oob_cnt;
      run_job(B2B[k], cyc);
      chk_cnt++;
      if (DONE !== 1'b1 || cyc > n + m + 8)
        $display("FAIL b2b_latency mnt=%h got cyc=%0d done=%b want done within %0d", B2B[k], cyc, DONE, n + m + 8);
      else pass_cnt++;
      chk_cnt++;
      if (done_cnt - d0 != 1 || oob_cnt - o0 != 0)
        $display("FAIL b2b_pulses mnt=%h got done=%0d oob=%0d want 1/0", B2B[k], done_cnt - d0, oob_cnt - o0);
      else pass_cnt++;
      for (int r = 0; r < 16; r++) begin
        chk_cnt++;
        if (mem_o[r] !== ref_row(r, m, n, t))
          $display("FAIL b2b_row mnt=%h row%0d got %h want %h", B2B[k], r, mem_o[r], ref_row(r, m, n, t));
        else pass_cnt++;
      end
      fill_rand();
      clr_o = 1'b1;
    end
    @(negedge CLK); @(negedge CLK);
  endtask

  task automatic test_zero_dim();
    logic [11:0] mnt;
    int cyc, d0, e0;
    for (int k = 0; k < 2; k++) begin
      mnt = (k == 0) ? 12'h048 : 12'h880;
      clr_o = 1'b1; d0 = done_cnt; e0 = en_i_cnt + en_w_cnt + en_o_cnt;
      run_job(mnt, cyc);
      chk_cnt++;
      if (DONE !== 1'b1 || cyc > 3) $display("FAIL zero_latency mnt=%h got cyc=%0d done=%b want <=3", mnt, cyc, DONE);
      else pass_cnt++;
      @(negedge CLK); @(negedge CLK);
      chk_cnt++;
      if (done_cnt - d0 != 1) $display("FAIL zero_done_pulses got %0d want 1", done_cnt - d0); else pass_cnt++;
      chk_cnt++;
      if (en_i_cnt + en_w_cnt + en_o_cnt - e0 != 0)
        $display("FAIL zero_mem_access got %0d want 0", en_i_cnt + en_w_cnt + en_o_cnt - e0);
      else pass_cnt++;
      for (int r = 0; r < 16; r++) begin
        chk_cnt++;
        if (mem_o[r] !== SENT) $display("FAIL zero_row row%0d got %h want %h", r, mem_o[r], SENT); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, d0, e0;
    fill_rand();
    clr_o = 1'b1;
    @(negedge CLK);
    START = 1'b1; MNT = 12'h888; clr_o = 1'b0; cur_m = 8;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    chk_cnt++;
    if (EN_I !== 1'b1) $display("FAIL mid_in_compute got en_i=%b want 1", EN_I); else pass_cnt++;
    RST = 1'b1;
    #1;
    chk_cnt++;
    if (outs !== '0) $display("FAIL mid_async_clear got %h want 0", outs); else pass_cnt++;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    d0 = done_cnt; e0 = en_i_cnt + en_w_cnt + en_o_cnt;
    repeat (20) @(negedge CLK);
    chk_cnt++;
    if (done_cnt - d0 != 0) $display("FAIL mid_no_done got %0d want 0", done_cnt - d0); else pass_cnt++;
    chk_cnt++;
    if (en_i_cnt + en_w_cnt + en_o_cnt - e0 != 0)
      $display("FAIL mid_no_access got %0d want 0", en_i_cnt + en_w_cnt + en_o_cnt - e0);
    else pass_cnt++;
    clr_o = 1'b1;
    run_job(12'h888, cyc);
    chk_cnt++;
    if (DONE !== 1'b1) $display("FAIL mid_restart_done got cyc=%0d done=%b want done", cyc, DONE); else pass_cnt++;
    @(negedge CLK);
    for (int r = 0; r < 16; r++) begin
      chk_cnt++;
      if (mem_o[r] !== ref_row(r, 8, 8, 8))
        $display("FAIL mid_restart_row row%0d got %h want %h", r, mem_o[r], ref_row(r, 8, 8, 8));
      else pass_cnt++;
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; MNT = '0; clr_o = 1'b0; cur_m = 0;
    test_reset();
    test_ones();
    test_wrap();
    test_clamp();
    test_back_to_back();
    test_zero_dim();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got no finish want finish before time limit");
    $fatal(1);
  end
endmodule

// File: doc/wssa_mac_top.md
Name: wssa_mac_top

Overview:
- Weight-stationary int8 matrix-multiply engine.
- Computes C[M×N] = A[M×T] · B[T×N] from two 8-entry, 64-bit, 1-cycle-latency BRAMs.
  - A is the input matrix, stored row-major.
  - B is the weight matrix, stored transposed: row n holds column n of B.
- Writes 16-bit results to a 128-bit × 16-entry output BRAM.
- Sits between the bram_test memory instances and the host control logic: START/DONE handshake, with matrix dimensions supplied on MNT.

Parameters:
- DW, 8, operand width (signed int8).
- ARR, 8, maximum M, N, T; also the lane count per memory word.
- OW, 16, accumulator/result lane width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- MNT  in  12  {M[11:8], N[7:4], T[3:0]}; sampled when START is accepted.
- START  in  1  one-cycle start pulse.
- DONE  out  1  one-cycle completion pulse.
- EN_I  out  1  input-memory enable.
- ADDR_I  out  3  input row address.
- RDATA_I  in  64  input row data. Byte k = A[row][k], at bits [8k+7:8k].
- EN_W  out  1  weight-memory enable.
- ADDR_W  out  3  weight row address n.
- RDATA_W  in  64  weight row data. Byte t = B[t][n].
- EN_O  out  1  output-memory enable.
- RW_O  out  1  1 = write, 0 = read.
- ADDR_O  out  4  output row address.
- WDATA_O  out  128  output row data. Lane j at bits [16j+15:16j] = C[row][j].
- RDATA_O  in  128  output read data; unused, ignored.

Behaviour:
- Reset: all outputs 0, FSM returns to IDLE, weight registers cleared. Reset mid-operation aborts immediately; no further memory access and no DONE.
- Memories:
  - Read data is valid on the cycle after EN is asserted with an address.
  - A write occurs at the edge where EN_O=1 and RW_O=1.
- FSM states: IDLE, LOAD_W, COMPUTE, WRITE, FINISH.
- IDLE:
  - START=1 latches MNT.
  - Each field is clamped: values >8 become 8.
  - If any field is 0, go to FINISH with no memory accesses.
  - Otherwise go to LOAD_W.
  - START outside IDLE is ignored.
- LOAD_W:
  - Issues weight reads at addresses 0..N-1 on consecutive cycles.
  - Each returned row is stored in an 8×8 stationary weight register array, column n.
  - Weight bytes t≥T are treated as 0.
- COMPUTE:
  - Issues input reads at rows 0..M-1 on consecutive cycles.
  - For each returned row, computes all 8 lanes in parallel:
    - lane j = Σ_{t<T} A[t]·W[t][j], signed×signed.
    - Sum is accumulated and truncated to 16 bits, two's-complement wrap.
    - Lanes j≥N are forced to 0.
- WRITE:
  - Row i is written to ADDR_O=i with EN_O=RW_O=1.
  - Writes may be pipelined, one row per cycle.
  - Only addresses 0..M-1 are written; addresses M..15 are never touched.
  - EN_O=0 at all other times.
- FINISH:
  - DONE=1 for exactly one cycle, on the cycle after the edge that performed the last write. All results are therefore in memory when DONE rises.
  - Then return to IDLE.
- Total START-to-DONE latency ≤ N+M+8 cycles.
- EN_I and EN_W are never high outside their phases. Addresses hold their last value when EN is low.
- Back-to-back runs: a new START is accepted in the cycle after DONE. Weights are always reloaded on each run.

Optional Feature:
- Macro WSSA_SAT_EN.
- Defined: each lane's final sum saturates to the [-32768, 32767] range instead of wrapping. The sum is computed at 20 bits internally, then clamped.
- Undefined: 16-bit wrap-around. This is the default and golden-vector behaviour.

Test Plan:
- All A bytes 0x01, all B bytes 0x01, MNT=0x888 → rows 0-7 each 0x0008 in every lane. Rows 8-15 keep their cleared value. DONE pulses once.
- Same data, MNT=0x444 → rows 0-3 have lanes 0-3 = 0x0004 and lanes 4-7 = 0x0000. Rows 4-15 are untouched.
- A bytes 0x80, B bytes 0x7F, MNT=0x113 → row 0 lane 0 = 0x4180 (wrapped -48768). With WSSA_SAT_EN the result is 0x8000.
- Run all eight MNT values 0x444, 0x337, 0x374, 0x376, 0x634, 0x738, 0x583, 0x555 back-to-back, clearing memory between runs. Each run must match the software A·B golden rows; e.g. 0x583 writes rows 0-4 only, lanes 0-7 each a 3-term sum.
- Assert RST mid-COMPUTE with MNT=0x888 → all outputs drop to 0 immediately and DONE never pulses. A subsequent START completes normally.
- MNT=0x048 (M=0) → no EN_I/EN_W/EN_O activity. DONE pulses within 3 cycles.
